codeword_bank_sel: RTL and testbench
====================================

CODEWORD_BANK_SEL -- requirements
Module: codeword_bank_sel

Interface
REQ-001 SHALL have parameter ANTS, default 32, meaning antennas per codeword.
REQ-002 SHALL have parameter BEAM, default 16, meaning output beam lanes.
REQ-003 SHALL have parameter WIDTH, default 32, meaning bits per antenna weight.
REQ-004 SHALL have parameter DEPTH, default 64, meaning codebook entries; power of 2 and a multiple of BEAM; PH = DEPTH/BEAM phases.
REQ-005 SHALL have parameter ROM_LAT, default 4, meaning ROM read latency in cycles; must be at least 1.
REQ-006 Port i_clk, input, 1, meaning the single clock.
REQ-007 Port i_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-008 Port i_load, input, 1, meaning pulse that starts a codebook load.
REQ-009 Port o_rom_rden / o_rom_addr, output, 1 / log2(DEPTH), meaning ROM read port.
REQ-010 Port i_rom_rdata_even / i_rom_rdata_odd, input, WIDTH*ANTS each, meaning ROM data.
REQ-011 Port i_symb_clr / i_symb_1st / i_rbg_load, input, 1 each, meaning selection events.
REQ-012 Port i_symb_idx, input, 8, meaning symbol index; bits [log2(PH)-1:0] give the phase.
REQ-013 Port i_beam_idx, input, BEAM*8, meaning per-lane codebook index.
REQ-014 Port i_err_clr, input, 1, meaning clear for o_idx_err.
REQ-015 Port o_cw_even / o_cw_odd, output, BEAM*WIDTH*ANTS each, meaning selected codewords.
REQ-016 Port o_tvalid / o_busy / o_idx_err, output, 1 each, meaning table valid / load in progress / sticky index error.

Function
REQ-017 The load FSM SHALL have states IDLE, READ, DRAIN and DONE: IDLE->READ on i_load; READ->DRAIN after DEPTH reads; DRAIN->DONE after ROM_LAT cycles; DONE->IDLE unconditionally.
REQ-018 In READ, o_rom_rden SHALL be high for exactly DEPTH consecutive cycles, starting the cycle after i_load is sampled, with o_rom_addr stepping 0..DEPTH-1 ascending.
REQ-019 Data returned ROM_LAT cycles after address k was presented SHALL be written to table entry k, in separate even and odd tables.
REQ-020 o_tvalid SHALL rise the cycle after the last entry is written (cycle DEPTH+ROM_LAT+1 relative to i_load) and stay high until the next accepted i_load.
REQ-021 o_busy SHALL be high in READ and DRAIN.
REQ-022 An i_load received in READ or DRAIN SHALL be ignored.
REQ-023 An i_load received in IDLE with o_tvalid=1 SHALL drop o_tvalid on the next cycle and restart the load.
REQ-024 While o_tvalid=0, all selection events SHALL be ignored and o_cw_* SHALL hold their values.
REQ-025 Selection latency SHALL be 1 cycle: outputs update on the edge that samples the event.
REQ-026 Selection priority SHALL be i_symb_clr > i_symb_1st > i_rbg_load.
REQ-027 On i_symb_clr, lane i SHALL receive entry i.
REQ-028 On i_symb_1st, lane i SHALL receive entry i + BEAM*phase.
REQ-029 On i_rbg_load, lane i SHALL receive entry i_beam_idx[i].
REQ-030 Even and odd outputs SHALL always use the same index.
REQ-031 If i_beam_idx[i] >= DEPTH during i_rbg_load, lane i SHALL receive entry 0 and o_idx_err SHALL be set.
REQ-032 o_idx_err SHALL be sticky until i_err_clr; set SHALL win when set and clear occur in the same cycle.
REQ-033 With no event, outputs SHALL hold.

Reset
REQ-034 Asserting i_reset_n low SHALL immediately force FSM=IDLE, o_tvalid=0, o_busy=0, o_rom_rden=0, o_rom_addr=0, o_cw_*=0, o_idx_err=0; table contents are not reset.
REQ-035 Reset asserted during READ or DRAIN SHALL abort the load; a fresh i_load is required before o_tvalid rises.

Verification
REQ-036 Defaults; i_load at cycle 0; ROM model returns data = address, 4-cycle latency -> rden high on cycles 1..64 with addr 0..63; o_tvalid high at cycle 69; o_busy high on cycles 1..68.
REQ-037 After load, i_symb_1st with phase 2 -> next cycle lane i outputs entry 32+i on both even and odd.
REQ-038 i_rbg_load with lane 3 idx 70 and other lanes idx 5 -> lane 3 = entry 0, other lanes = entry 5; o_idx_err=1 until i_err_clr.
REQ-039 i_symb_clr, i_symb_1st and i_rbg_load together -> lane i = entry i.
REQ-040 Second i_load at cycle 30 of a load -> ignored, o_tvalid still rises at cycle 69; i_load after o_tvalid -> o_tvalid low next cycle, outputs held, events ignored until reload done.
REQ-041 i_reset_n pulsed low mid-READ -> all outputs 0 asynchronously; o_tvalid stays 0 until a full new load completes.

Source files
------------

// File: rtl/codeword_bank_sel_if.sv
// rtl/codeword_bank_sel_if.sv - codebook ROM read bus between codeword_bank_sel and its ROM
// Ports (master = selector side, slave = ROM side):
//   o_rom_rden        read strobe, one address per cycle
//   o_rom_addr        codebook entry address, log2(DEPTH) bits
//   i_rom_rdata_even  even-table entry data, WIDTH*ANTS bits
//   i_rom_rdata_odd   odd-table entry data, WIDTH*ANTS bits
interface codeword_bank_sel_if #(
    parameter int WIDTH = 32,
    parameter int ANTS  = 32,
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic                    o_rom_rden;
    logic [AW-1:0]           o_rom_addr;
    logic [WIDTH*ANTS-1:0]   i_rom_rdata_even;
    logic [WIDTH*ANTS-1:0]   i_rom_rdata_odd;

    modport master (
        output o_rom_rden,
        output o_rom_addr,
        input  i_rom_rdata_even,
        input  i_rom_rdata_odd
    );

    modport slave (
        input  o_rom_rden,
        input  o_rom_addr,
        output i_rom_rdata_even,
        output i_rom_rdata_odd
    );
endinterface

// File: rtl/codeword_bank_sel.sv
// rtl/codeword_bank_sel.sv - codebook loader and per-lane beam codeword selector
// Loads DEPTH even/odd codewords from a ROM into local tables, then on selection
// events drives one codeword per beam lane.
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_load                  start a codebook load (accepted only when idle)
//   rom                     ROM read bus (codeword_bank_sel_if.master)
//   i_symb_clr              select entry i for lane i
//   i_symb_1st, i_symb_idx  select entry i + BEAM*phase, phase from low symbol-index bits
//   i_rbg_load, i_beam_idx  select per-lane entry from 8-bit indices
//   i_err_clr               clear the sticky index error
//   o_cw_even, o_cw_odd     selected codewords, lane i at [i*WIDTH*ANTS +: WIDTH*ANTS]
//   o_tvalid, o_busy        table valid, load in progress
//   o_idx_err               sticky out-of-range beam index
module codeword_bank_sel #(
    parameter int ANTS    = 32,
    parameter int BEAM    = 16,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int ROM_LAT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_load,
    codeword_bank_sel_if.master         rom,
    input  logic                        i_symb_clr,
    input  logic                        i_symb_1st,
    input  logic                        i_rbg_load,
    input  logic [7:0]                  i_symb_idx,
    input  logic [BEAM*8-1:0]           i_beam_idx,
    input  logic                        i_err_clr,
    output logic [BEAM*WIDTH*ANTS-1:0]  o_cw_even,
    output logic [BEAM*WIDTH*ANTS-1:0]  o_cw_odd,
    output logic                        o_tvalid,
    output logic                        o_busy,
    output logic                        o_idx_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PH = DEPTH / BEAM;
    localparam int WW = WIDTH * ANTS;
    localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]   dr_cnt_q, dr_cnt_d;
    logic            tvalid_q, tvalid_d;
    logic [AW-1:0]   wr_cnt_q;
    logic [ROM_LAT-1:0] vld_sr_q;
    logic            load_go;
    logic            wr_en;

    logic [WW-1:0]   tab_even [DEPTH];
    logic [WW-1:0]   tab_odd  [DEPTH];

    logic [AW-1:0]   sel_idx [BEAM];
    logic            sel_hit;
    logic            sel_err;
    logic [7:0]      phase;

    // Load FSM: next state and counters
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        dr_cnt_d = dr_cnt_q;
        tvalid_d = tvalid_q;
        load_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    load_go  = 1'b1;
                    state_d  = READ;
                    rd_cnt_d = '0;
                    tvalid_d = 1'b0;
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == AW'(DEPTH - 1)) begin
                    state_d  = DRAIN;
                    dr_cnt_d = '0;
                end
            end
            DRAIN: begin
                dr_cnt_d = dr_cnt_q + 1'b1;
                // The last read returns in the final drain cycle and is written on
                // this same edge, so the table is complete when tvalid rises.
                if (dr_cnt_q == DW'(ROM_LAT - 1)) begin
                    state_d  = DONE;
                    tvalid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            dr_cnt_q <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            dr_cnt_q <= dr_cnt_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign rom.o_rom_rden = (state_q == READ);
    assign rom.o_rom_addr = rd_cnt_q;
    assign o_busy         = (state_q == READ) || (state_q == DRAIN);
    assign o_tvalid       = tvalid_q;

    // Read strobes delayed by the ROM latency mark which cycles carry return data;
    // reads are sequential so a plain write counter supplies the entry number.
    assign wr_en = vld_sr_q[ROM_LAT-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_sr_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            vld_sr_q <= (vld_sr_q << 1) | ROM_LAT'(rom.o_rom_rden);
            if (load_go) begin
                wr_cnt_q <= '0;
            end else if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            tab_even[wr_cnt_q] <= rom.i_rom_rdata_even;
            tab_odd[wr_cnt_q]  <= rom.i_rom_rdata_odd;
        end
    end

    // Per-lane entry selection, i_symb_clr > i_symb_1st > i_rbg_load
    always_comb begin
        sel_hit = tvalid_q && (i_symb_clr || i_symb_1st || i_rbg_load);
        sel_err = 1'b0;
        phase   = i_symb_idx & 8'(PH - 1);
        for (int l = 0; l < BEAM; l++) begin
            sel_idx[l] = AW'(l);
            if (!i_symb_clr && i_symb_1st) begin
                sel_idx[l] = AW'(l + BEAM * int'(phase));
            end else if (!i_symb_clr && i_rbg_load) begin
                if (int'(i_beam_idx[l*8 +: 8]) >= DEPTH) begin
                    sel_idx[l] = '0;
                    sel_err    = tvalid_q;
                end else begin
                    sel_idx[l] = AW'(i_beam_idx[l*8 +: 8]);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cw_even <= '0;
            o_cw_odd  <= '0;
        end else if (sel_hit) begin
            for (int l = 0; l < BEAM; l++) begin
                o_cw_even[l*WW +: WW] <= tab_even[sel_idx[l]];
                o_cw_odd[l*WW +: WW]  <= tab_odd[sel_idx[l]];
            end
        end
    end

    // Set wins over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_idx_err <= 1'b0;
        end else if (sel_err) begin
            o_idx_err <= 1'b1;
        end else if (i_err_clr) begin
            o_idx_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_codeword_bank_sel.sv
// tb/tb_codeword_bank_sel.sv - self-checking bench for codeword_bank_sel
module tb_codeword_bank_sel;
    localparam int ANTS = 32, BEAM = 16, WIDTH = 32, DEPTH = 64, ROM_LAT = 4;
    localparam int PH = DEPTH / BEAM;
    localparam int LW = WIDTH * ANTS;
    localparam int AW = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic                 i_load = 1'b0;
    logic                 i_symb_clr = 1'b0, i_symb_1st = 1'b0, i_rbg_load = 1'b0;
    logic [7:0]           i_symb_idx = '0;
    logic [BEAM*8-1:0]    i_beam_idx = '0;
    logic                 i_err_clr = 1'b0;
    logic [BEAM*LW-1:0]   o_cw_even, o_cw_odd;
    logic                 o_tvalid, o_busy, o_idx_err;

    int total = 0;
    int bad   = 0;

    codeword_bank_sel_if #(.WIDTH(WIDTH), .ANTS(ANTS), .DEPTH(DEPTH)) rom_if ();

    codeword_bank_sel #(
        .ANTS(ANTS), .BEAM(BEAM), .WIDTH(WIDTH), .DEPTH(DEPTH), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_load     (i_load),
        .rom        (rom_if),
        .i_symb_clr (i_symb_clr),
        .i_symb_1st (i_symb_1st),
        .i_rbg_load (i_rbg_load),
        .i_symb_idx (i_symb_idx),
        .i_beam_idx (i_beam_idx),
        .i_err_clr  (i_err_clr),
        .o_cw_even  (o_cw_even),
        .o_cw_odd   (o_cw_odd),
        .o_tvalid   (o_tvalid),
        .o_busy     (o_busy),
        .o_idx_err  (o_idx_err)
    );

    // Each antenna word carries a table tag, antenna number and entry address.
    function automatic logic [LW-1:0] rom_word(int a, bit odd);
        logic [LW-1:0] w;
        for (int k = 0; k < ANTS; k++)
            w[k*WIDTH +: WIDTH] = {(odd ? 16'hB0DD : 16'hE7E7), 8'(k), 8'(a)};
        return w;
    endfunction

    // ROM: data for an address appears ROM_LAT cycles after it was presented
    logic rv [ROM_LAT] = '{default: 1'b0};
    int   ra [ROM_LAT] = '{default: 0};
    always @(posedge clk) begin
        rv[0] <= rom_if.o_rom_rden;
        ra[0] <= int'(rom_if.o_rom_addr);
        for (int s = 1; s < ROM_LAT; s++) begin
            rv[s] <= rv[s-1];
            ra[s] <= ra[s-1];
        end
    end
    assign rom_if.i_rom_rdata_even = rv[ROM_LAT-1] ? rom_word(ra[ROM_LAT-1], 1'b0) : '0;
    assign rom_if.i_rom_rdata_odd  = rv[ROM_LAT-1] ? rom_word(ra[ROM_LAT-1], 1'b1) : '0;

    // Reference model: which entry each lane shows, or all-zero after reset
    int m_idx [BEAM];
    bit m_zero = 1'b1;
    bit m_valid = 1'b0;
    bit m_err = 1'b0;

    function automatic logic [BEAM*LW-1:0] exp_cw(bit odd);
        logic [BEAM*LW-1:0] v;
        for (int l = 0; l < BEAM; l++)
            v[l*LW +: LW] = m_zero ? '0 : rom_word(m_idx[l], odd);
        return v;
    endfunction

    task automatic model_evt();
        bit seterr = 1'b0;
        if (m_valid && (i_symb_clr || i_symb_1st || i_rbg_load)) begin
            m_zero = 1'b0;
            for (int l = 0; l < BEAM; l++) begin
                int b = int'(i_beam_idx[l*8 +: 8]);
                if (i_symb_clr)       m_idx[l] = l;
                else if (i_symb_1st)  m_idx[l] = l + BEAM * (int'(i_symb_idx) % PH);
                else if (b >= DEPTH) begin m_idx[l] = 0; seterr = 1'b1; end
                else                  m_idx[l] = b;
            end
        end
        if (seterr) m_err = 1'b1;
        else if (i_err_clr) m_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_evt();
        i_symb_clr = 1'b0; i_symb_1st = 1'b0; i_rbg_load = 1'b0; i_err_clr = 1'b0;
    endtask

    task automatic rand_evt(bit with_err_clr);
        i_symb_clr = ($urandom_range(0, 5) == 0);
        i_symb_1st = ($urandom_range(0, 3) == 0);
        i_rbg_load = $urandom_range(0, 1) == 1;
        i_symb_idx = 8'($urandom);
        for (int l = 0; l < BEAM; l++) i_beam_idx[l*8 +: 8] = 8'($urandom_range(0, DEPTH + 15));
        i_err_clr  = with_err_clr && ($urandom_range(0, 3) == 0);
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic chk_cw(string tag);
        for (int odd = 0; odd < 2; odd++) begin
            logic [BEAM*LW-1:0] got, want;
            int ln = 0;
            got  = odd ? o_cw_odd : o_cw_even;
            want = exp_cw(odd[0]);
            for (int l = BEAM - 1; l >= 0; l--)
                if (got[l*LW +: LW] !== want[l*LW +: LW]) ln = l;
            total++;
            assert (got === want) else begin
                bad++;
                $error("FAIL %s_%s lane %0d got=%h want=%h", tag, odd ? "odd" : "even",
                       ln, got[ln*LW +: 32], want[ln*LW +: 32]);
            end
        end
    endtask

    task automatic chk_state(string tag);
        chk({tag, "_tvalid"}, 32'(o_tvalid), 32'(m_valid));
        chk({tag, "_err"}, 32'(o_idx_err), 32'(m_err));
        chk_cw(tag);
    endtask

    // Load starting now; random events (which must be ignored) every cycle,
    // optional second i_load at cycle extra_at
    task automatic run_load(int extra_at);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        m_valid = 1'b0;
        for (int k = 1; k <= 69; k++) begin
            chk("ld_rden", 32'(rom_if.o_rom_rden), 32'(k <= DEPTH));
            if (k <= DEPTH) chk("ld_addr", 32'(rom_if.o_rom_addr), 32'(k - 1));
            chk("ld_busy", 32'(o_busy), 32'(k <= DEPTH + ROM_LAT));
            chk("ld_tvalid", 32'(o_tvalid), 32'(k >= DEPTH + ROM_LAT + 1));
            if (k < 69) begin
                chk_cw("ld_hold");
                i_load = (k == extra_at);
                rand_evt(1'b0);
                tick();
                model_evt();
                i_load = 1'b0;
                clear_evt();
            end
        end
        m_valid = 1'b1;
    endtask

    initial begin
        for (int l = 0; l < BEAM; l++) m_idx[l] = 0;

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rden", 32'(rom_if.o_rom_rden), 32'd0);
        chk("rst_addr", 32'(rom_if.o_rom_addr), 32'd0);
        chk_state("rst");
        rst_n = 1'b1;
        tick();

        // First load, with an i_load during READ that must be ignored
        run_load(30);
        chk_state("load_done");

        // i_symb_1st, phase 2 from the low bits of the symbol index
        i_symb_1st = 1'b1; i_symb_idx = 8'hF6;
        tick(); model_evt(); clear_evt();
        chk_state("symb1st");

        // Lane 3 out of range, others 5
        for (int l = 0; l < BEAM; l++) i_beam_idx[l*8 +: 8] = (l == 3) ? 8'd70 : 8'd5;
        i_rbg_load = 1'b1;
        tick(); model_evt(); clear_evt();
        chk_state("rbg_err");
        tick(); tick();
        chk_state("hold");
        i_err_clr = 1'b1;
        tick(); model_evt(); clear_evt();
        chk_state("err_clr");

        // Set beats clear in the same cycle
        i_rbg_load = 1'b1; i_err_clr = 1'b1;
        tick(); model_evt(); clear_evt();
        chk_state("err_setwin");

        // All three events together: clear has priority
        i_symb_clr = 1'b1; i_symb_1st = 1'b1; i_rbg_load = 1'b1; i_symb_idx = 8'd1;
        tick(); model_evt(); clear_evt();
        chk_state("prio");

        // Randomized selection traffic
        for (int n = 0; n < 60; n++) begin
            rand_evt(1'b1);
            tick(); model_evt(); clear_evt();
            chk_state("rand");
        end

        // Reload: tvalid drops, outputs hold, events ignored until done
        run_load(-1);
        chk_state("reload_done");
        i_symb_1st = 1'b1; i_symb_idx = 8'd3;
        tick(); model_evt(); clear_evt();
        chk_state("reload_sel");

        // Reset in the middle of READ
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("mid_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_zero = 1'b1; m_err = 1'b0;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_rden", 32'(rom_if.o_rom_rden), 32'd0);
        chk("arst_addr", 32'(rom_if.o_rom_addr), 32'd0);
        chk_state("arst");
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            rand_evt(1'b0);
            tick(); model_evt(); clear_evt();
            chk("post_rst_tvalid", 32'(o_tvalid), 32'd0);
            chk("post_rst_busy", 32'(o_busy), 32'd0);
        end
        chk_cw("post_rst");

        run_load(-1);
        chk_state("fresh_load");
        i_symb_clr = 1'b1;
        tick(); model_evt(); clear_evt();
        chk_state("fresh_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
